// File: rtl/link_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_table_pkg
// Brief    : Shared widths and FSM encodings for the link-table packet buffer
// Revision : 1.0 - initial release
// ============================================================================
package link_table_pkg;

  localparam int c_DATA_WIDTH        = 32;
  localparam int c_ADDR_PAGE_NUM_LOG = 6;
  localparam int c_PAGE_WORD_LOG     = 2;
  localparam int c_RAM_ADDR_WIDTH    = c_ADDR_PAGE_NUM_LOG + c_PAGE_WORD_LOG;

  localparam int c_STATE_WIDTH = 2;
  localparam logic [c_STATE_WIDTH-1:0] c_ST_IDLE  = 2'd0;
  localparam logic [c_STATE_WIDTH-1:0] c_ST_WRITE = 2'd1;
  localparam logic [c_STATE_WIDTH-1:0] c_ST_ALLOC = 2'd2;
  localparam logic [c_STATE_WIDTH-1:0] c_ST_DESC  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pop_pacer.sv
`default_nettype none
// ============================================================================
// Module   : pop_pacer
// Brief    : Spaces free-page pops by at least POP_LAT cycles
// Revision : 1.0 - initial release
// ============================================================================
module pop_pacer #(
  parameter int POP_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pop,
  output logic pop_ok
);

  localparam int c_TW = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;

  logic [c_TW-1:0] r_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (pop) begin
      r_timer <= c_TW'(POP_LAT - 1);
    end else if (r_timer != '0) begin
      r_timer <= r_timer - c_TW'(1);
    end
  end

  assign pop_ok = (r_timer == '0);

endmodule
`default_nettype wire

// File: rtl/pkg_write_controller.sv
`default_nettype none
// ============================================================================
// Module   : pkg_write_controller
// Brief    : Packet ingress - pops free pages, writes page/link RAM, emits descriptor
// Revision : 1.0 - initial release
// ============================================================================
module pkg_write_controller
  import link_table_pkg::*;
#(
  parameter int DATA_WIDTH        = c_DATA_WIDTH,
  parameter int ADDR_PAGE_NUM_LOG = c_ADDR_PAGE_NUM_LOG,
  parameter int PAGE_WORD_LOG     = c_PAGE_WORD_LOG,
  parameter int LEN_WIDTH         = 12,
  parameter int POP_LAT           = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic                                 empty_table_read_req,
  input  logic [ADDR_PAGE_NUM_LOG-1:0]         empty_table_read_addr,
  input  logic                                 empty_table_empty,
  output logic                                 ram_write_en,
  output logic [ADDR_PAGE_NUM_LOG+PAGE_WORD_LOG-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0]                ram_write_data,
  output logic                                 link_write_en,
  output logic [ADDR_PAGE_NUM_LOG-1:0]         link_write_addr,
  output logic [ADDR_PAGE_NUM_LOG-1:0]         link_write_data,
  output logic                                 desc_valid,
  input  logic                                 desc_ready,
  output logic [ADDR_PAGE_NUM_LOG-1:0]         desc_head,
  output logic [ADDR_PAGE_NUM_LOG-1:0]         desc_tail,
  output logic [LEN_WIDTH-1:0]                 desc_len
);

  localparam int c_RAM_AW = ADDR_PAGE_NUM_LOG + PAGE_WORD_LOG;

  logic [c_STATE_WIDTH-1:0]     r_state;
  logic [c_STATE_WIDTH-1:0]     w_state_nxt;
  logic                         w_pop_ok;
  logic                         w_pop_fire;
  logic                         w_in_ready;
  logic                         w_desc_valid;
  logic                         w_accept;

  logic [ADDR_PAGE_NUM_LOG-1:0] r_cur_page;
  logic [ADDR_PAGE_NUM_LOG-1:0] r_head;
  logic [ADDR_PAGE_NUM_LOG-1:0] r_tail;
  logic [PAGE_WORD_LOG-1:0]     r_offset;
  logic [LEN_WIDTH-1:0]         r_len;
  logic                         r_read_req;
  logic                         r_ram_we;
  logic [c_RAM_AW-1:0]          r_ram_addr;
  logic [DATA_WIDTH-1:0]        r_ram_data;
  logic                         r_link_we;
  logic [ADDR_PAGE_NUM_LOG-1:0] r_link_addr;
  logic [ADDR_PAGE_NUM_LOG-1:0] r_link_data;

  pop_pacer #(
    .POP_LAT (POP_LAT)
  ) u_pop_pacer (
    .clk    (clk),
    .rst    (rst),
    .pop    (w_pop_fire),
    .pop_ok (w_pop_ok)
  );

  assign w_accept = in_valid & w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_pop_fire) w_state_nxt = c_ST_WRITE;
      c_ST_WRITE: begin
        // last word wins over page-full so a boundary-aligned packet takes no spare page
        if (w_accept) begin
          if (in_last) begin
            w_state_nxt = c_ST_DESC;
          end else if (&r_offset) begin
            w_state_nxt = c_ST_ALLOC;
          end
        end
      end
      c_ST_ALLOC: if (w_pop_fire) w_state_nxt = c_ST_WRITE;
      c_ST_DESC:  if (desc_ready) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready   = 1'b0;
    w_desc_valid = 1'b0;
    w_pop_fire   = 1'b0;
    case (r_state)
      c_ST_IDLE:  w_pop_fire   = in_valid & w_pop_ok & ~empty_table_empty;
      c_ST_WRITE: w_in_ready   = 1'b1;
      c_ST_ALLOC: w_pop_fire   = w_pop_ok & ~empty_table_empty;
      c_ST_DESC:  w_desc_valid = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_page  <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_offset    <= '0;
      r_len       <= '0;
      r_read_req  <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_link_we   <= 1'b0;
      r_link_addr <= '0;
      r_link_data <= '0;
    end else begin
      r_read_req <= 1'b0;
      r_ram_we   <= 1'b0;
      r_link_we  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_pop_fire) begin
            r_read_req <= 1'b1;
            r_head     <= empty_table_read_addr;
            r_cur_page <= empty_table_read_addr;
            r_offset   <= '0;
            r_len      <= '0;
          end
        end
        c_ST_WRITE: begin
          if (w_accept) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= {r_cur_page, r_offset};
            r_ram_data <= in_data;
            r_offset   <= r_offset + PAGE_WORD_LOG'(1);
            if (~&r_len) r_len <= r_len + LEN_WIDTH'(1);
            if (in_last) r_tail <= r_cur_page;
          end
        end
        c_ST_ALLOC: begin
          if (w_pop_fire) begin
            r_read_req  <= 1'b1;
            r_link_we   <= 1'b1;
            r_link_addr <= r_cur_page;
            r_link_data <= empty_table_read_addr;
            r_cur_page  <= empty_table_read_addr;
            r_offset    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready             = w_in_ready;
  assign desc_valid           = w_desc_valid;
  assign empty_table_read_req = r_read_req;
  assign ram_write_en         = r_ram_we;
  assign ram_write_addr       = r_ram_addr;
  assign ram_write_data       = r_ram_data;
  assign link_write_en        = r_link_we;
  assign link_write_addr      = r_link_addr;
  assign link_write_data      = r_link_data;
  assign desc_head            = r_head;
  assign desc_tail            = r_tail;
  assign desc_len             = r_len;

endmodule
`default_nettype wire
